pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
Receive-side counterpart of the pwm generator. It samples an external PWM waveform and measures its period and high time in clk cycles. It then computes the integer duty cycle in percent with a bit-serial divider. Sits at the pwm_out pins of a generator, or at a board input, as a closed-loop monitor and self-check.

Parameters:
CNT_W, 16, width of period/high-time counters; max measurable period 2^CNT_W-2 cycles
SYNC_STAGES, 2, number of synchroniser flops on pwm_in (minimum 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
pwm_in  input  1  asynchronous PWM input
period  output  CNT_W  last measured period, clk cycles
high_time  output  CNT_W  last measured high time, clk cycles
duty_pct  output  7  floor(high_time*100/period), range 0..100
meas_valid  output  1  one-cycle pulse when period/high_time/duty_pct update
busy  output  1  divider running
stuck_hi  output  1  input held high longer than counter range
stuck_lo  output  1  input held low longer than counter range
overrun  output  1  one-cycle pulse: edge arrived while busy, measurement dropped

Behaviour:
- Reset (rst_n=0, async assert, sync deassert by use): all outputs 0, sync flops 0, FSM IDLE, disarmed.
- Synchroniser: pwm_in passes through SYNC_STAGES flops. Rise = synced 1 and previous synced 0; fall likewise.
- per_cnt: loaded with 1 on rise cycle, +1 every other cycle, saturates at all-ones.
- hi_cnt: loaded with 1 on rise cycle, +1 on cycles with synced=1, held otherwise, saturates.
- Rise while disarmed: arm only, no measurement. Clears stuck_hi/stuck_lo.
- Rise while armed and FSM IDLE: capture P=per_cnt and H=hi_cnt before reload, then start the divider. Numerator = H*100 (CNT_W+7 bits), denominator = P.
- Rise while armed and FSM not IDLE: drop the sample, pulse overrun, counters still reload.
- Saturation: per_cnt reaches all-ones while armed. Disarm and set stuck_hi if synced=1, else stuck_lo. duty_pct forced to 100 (hi) or 0 (lo), with a meas_valid pulse. period and high_time are left unchanged.
- FSM states:
  - IDLE -> DIV on accepted capture.
  - DIV: restoring division, one quotient bit per cycle, CNT_W+7 cycles; busy=1.
  - DIV -> DONE: load period=P, high_time=H, duty_pct=min(quotient,100); meas_valid=1 for that cycle.
  - DONE -> IDLE.
- Latency: meas_valid asserts CNT_W+8 cycles after the rise-detect cycle (24 for default). Minimum measurable period without overrun is CNT_W+9 cycles.
- Truncating division; no rounding.
- Reset mid-division: abort, all outputs to reset values, first subsequent rise only arms.

Decomposition:
- Shared package pwm_pkg:
  - DUTY_W=7
  - PCT_SCALE=100
  - enum cap_state_t {IDLE, DIV, DONE}
  - DUTY_W is shared with the generator's duty width.
- One natural sub-module: pwm_div_serial. Generic NUM_W/DEN_W restoring divider with start/busy/done, used by pwm_capture.

Test Plan:
- Period 100, high 40, repeated: first rise only arms. Second rise: meas_valid 24 cycles later with period=100, high_time=40, duty_pct=40.
- Period 3, high 1 (below minimum): overrun pulses, no meas_valid. Then switch to period 50, high 17: duty_pct=34.
- pwm_in held 1 for 70000 cycles after arming: stuck_hi=1, duty_pct=100, meas_valid pulse. Next two rises: stuck cleared on first, normal measurement after second.
- pwm_in held 0: stuck_lo=1, duty_pct=0. Then period 200, high 199: duty_pct=99.
- rst_n low 10 cycles into DIV: outputs immediately 0, no meas_valid. After release, first rise arms only.
- Drive from generator at 10%..100% steps: duty_pct tracks each step within one period plus 24 cycles, with period constant.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and types for the pwm generator/capture pair
package pwm_pkg;

  localparam int DUTY_W    = 7;
  localparam int PCT_SCALE = 100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pwm_div_serial.sv
// rtl/pwm_div_serial.sv - restoring bit-serial divider, one quotient bit per clk
module pwm_div_serial #(
  parameter int NUM_W = 23,
  parameter int DEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int STEP_W = $clog2(NUM_W + 1);

  logic [DEN_W-1:0]  rem_q;
  logic [NUM_W-1:0]  quo_q;
  logic [DEN_W-1:0]  den_q;
  logic [STEP_W-1:0] cnt_q;
  logic              done_q;

  // Shift the next numerator bit into the remainder and keep the subtraction
  // only when it does not borrow. The remainder stays below den, so DEN_W bits suffice.
  function automatic logic [DEN_W+NUM_W-1:0] div_step(
    input logic [DEN_W-1:0] r,
    input logic [NUM_W-1:0] q,
    input logic [DEN_W-1:0] d
  );
    logic [DEN_W:0]   sh;
    logic [DEN_W+1:0] diff;
    sh   = {r, q[NUM_W-1]};
    diff = {1'b0, sh} - {2'b00, d};
    if (diff[DEN_W+1]) begin
      div_step = {sh[DEN_W-1:0], q[NUM_W-2:0], 1'b0};
    end else begin
      div_step = {diff[DEN_W-1:0], q[NUM_W-2:0], 1'b1};
    end
  endfunction

  // The first step happens on the start edge, so the quotient is final after NUM_W edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        {rem_q, quo_q} <= div_step('0, num, den);
        den_q          <= den;
        cnt_q          <= STEP_W'(NUM_W - 1);
      end else if (cnt_q != '0) begin
        {rem_q, quo_q} <= div_step(rem_q, quo_q, den_q);
        cnt_q          <= cnt_q - STEP_W'(1);
        done_q         <= (cnt_q == STEP_W'(1));
      end
    end
  end

  assign busy     = (cnt_q != '0);
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures period, high time and duty percent of an async PWM input
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty_pct,
  output logic              meas_valid,
  output logic              busy,
  output logic              stuck_hi,
  output logic              stuck_lo,
  output logic              overrun
);

  localparam int               NUM_W   = CNT_W + DUTY_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   synced_d;
  logic                   rise;

  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] cap_p;
  logic [CNT_W-1:0] cap_h;
  logic             armed;

  cap_state_t state_q;
  cap_state_t state_d;

  logic             sat_evt;
  logic             accept;
  logic             drop;
  logic             div_start;
  logic             load_result;
  logic             div_busy;
  logic             div_done;
  logic [NUM_W-1:0] div_num;
  logic [NUM_W-1:0] div_quo;
  logic [DUTY_W-1:0] duty_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      synced_d <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      synced_d <= synced;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~synced_d;

  // The rise cycle itself is high, so both counters restart at 1 rather than 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      if (rise) begin
        per_cnt <= CNT_W'(1);
      end else if (per_cnt != CNT_MAX) begin
        per_cnt <= per_cnt + CNT_W'(1);
      end
      if (rise) begin
        hi_cnt <= CNT_W'(1);
      end else if (synced && hi_cnt != CNT_MAX) begin
        hi_cnt <= hi_cnt + CNT_W'(1);
      end
    end
  end

  // A saturated period counter wins over a coincident edge: the period is out of range.
  assign sat_evt = armed && (per_cnt == CNT_MAX);
  assign accept  = rise && armed && !sat_evt && (state_q == IDLE);
  assign drop    = rise && armed && !sat_evt && (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      cap_p <= '0;
      cap_h <= '0;
    end else begin
      if (sat_evt) begin
        armed <= 1'b0;
      end else if (rise) begin
        armed <= 1'b1;
      end
      if (accept) begin
        cap_p <= per_cnt;
        cap_h <= hi_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_start   = 1'b0;
    load_result = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          load_result = 1'b1;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign div_num = NUM_W'(hi_cnt) * NUM_W'(PCT_SCALE);

  pwm_div_serial #(
    .NUM_W(NUM_W),
    .DEN_W(CNT_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start),
    .num     (div_num),
    .den     (per_cnt),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quo)
  );

  assign duty_next = (div_quo > NUM_W'(PCT_SCALE)) ? DUTY_W'(PCT_SCALE) : div_quo[DUTY_W-1:0];
  assign busy      = div_busy | (state_q == DIV);

  // A stuck input reports 0 % or 100 % but keeps the last real period/high time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period     <= '0;
      high_time  <= '0;
      duty_pct   <= '0;
      meas_valid <= 1'b0;
      stuck_hi   <= 1'b0;
      stuck_lo   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      overrun    <= drop;
      if (load_result) begin
        period     <= cap_p;
        high_time  <= cap_h;
        duty_pct   <= duty_next;
        meas_valid <= 1'b1;
      end
      if (sat_evt) begin
        stuck_hi   <= synced;
        stuck_lo   <= ~synced;
        duty_pct   <= synced ? DUTY_W'(PCT_SCALE) : '0;
        meas_valid <= 1'b1;
      end else if (rise && !armed) begin
        stuck_hi <= 1'b0;
        stuck_lo <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - event-level reference model and directed waveforms for pwm_capture
module tb_pwm_capture;

  localparam int CNT_W = 12;
  localparam int SS    = 2;
  localparam int LAT   = CNT_W + 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [6:0]       duty_pct;
  logic             meas_valid;
  logic             busy;
  logic             stuck_hi;
  logic             stuck_lo;
  logic             overrun;

  pwm_capture #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .duty_pct  (duty_pct),
    .meas_valid(meas_valid),
    .busy      (busy),
    .stuck_hi  (stuck_hi),
    .stuck_lo  (stuck_lo),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  // kind: 0 measurement, 1 overrun, 2 stuck high, 3 stuck low, 4 stuck cleared
  typedef struct {
    int due;
    int kind;
    int p;
    int h;
    int d;
  } ev_t;
  ev_t evq[$];

  bit prev_s = 1'b0;
  bit armed_m = 1'b0;
  bit acc_any = 1'b0;
  int last_rise = 0;
  int hi_count = 0;
  int acc_m = 0;
  int acc_cyc = 0;

  int exp_period = 0;
  int exp_high = 0;
  int exp_duty = 0;
  bit exp_valid = 1'b0;
  bit exp_ovr = 1'b0;
  bit exp_busy = 1'b0;
  bit exp_shi = 1'b0;
  bit exp_slo = 1'b0;

  int meas_cnt = 0;
  int ovr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic ev_t mk_ev(input int due, input int kind, input int p, input int h);
    ev_t e;
    int d;
    d = (p > 0) ? (h * 100) / p : 0;
    if (d > 100) d = 100;
    e.due = due;
    e.kind = kind;
    e.p = p;
    e.h = h;
    e.d = d;
    return e;
  endfunction

  // Model: works on raw input samples; an event seen at sample m shows at the
  // outputs after the synchroniser delay plus the divider latency where relevant.
  initial begin
    bit s;
    bit rise;
    bit sat;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        prev_s = 1'b0;
        armed_m = 1'b0;
        acc_any = 1'b0;
        hi_count = 0;
        evq.delete();
      end else begin
        s = pwm_in;
        rise = s && !prev_s;
        sat = armed_m && (cyc - last_rise == MAXC);
        if (sat) begin
          armed_m = 1'b0;
          evq.push_back(mk_ev(cyc + SS, s ? 2 : 3, 0, 0));
        end
        if (rise) begin
          if (!sat) begin
            if (!armed_m) begin
              armed_m = 1'b1;
              evq.push_back(mk_ev(cyc + SS, 4, 0, 0));
            end else if (acc_any && (cyc - acc_m <= LAT)) begin
              evq.push_back(mk_ev(cyc + SS, 1, 0, 0));
            end else begin
              evq.push_back(mk_ev(cyc + SS - 1 + LAT, 0, cyc - last_rise,
                                  (hi_count > MAXC) ? MAXC : hi_count));
              acc_any = 1'b1;
              acc_m = cyc;
              acc_cyc = cyc + SS - 1;
            end
          end
          last_rise = cyc;
          hi_count = 0;
        end
        if (s) hi_count++;
        prev_s = s;
      end
    end
  end

  initial begin
    int idx;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_period = 0;
        exp_high = 0;
        exp_duty = 0;
        exp_shi = 1'b0;
        exp_slo = 1'b0;
      end else if (cmp_en) begin
        exp_valid = 1'b0;
        exp_ovr = 1'b0;
        idx = 0;
        while (idx < evq.size()) begin
          if (evq[idx].due == cyc) begin
            case (evq[idx].kind)
              0: begin
                exp_period = evq[idx].p;
                exp_high = evq[idx].h;
                exp_duty = evq[idx].d;
                exp_valid = 1'b1;
              end
              1: exp_ovr = 1'b1;
              2: begin exp_shi = 1'b1; exp_slo = 1'b0; exp_duty = 100; exp_valid = 1'b1; end
              3: begin exp_shi = 1'b0; exp_slo = 1'b1; exp_duty = 0; exp_valid = 1'b1; end
              default: begin exp_shi = 1'b0; exp_slo = 1'b0; end
            endcase
            evq.delete(idx);
          end else begin
            idx++;
          end
        end
        exp_busy = acc_any && (cyc > acc_cyc) && (cyc < acc_cyc + LAT);
        check("period", period, exp_period);
        check("high_time", high_time, exp_high);
        check("duty_pct", duty_pct, exp_duty);
        check("meas_valid", meas_valid, exp_valid);
        check("overrun", overrun, exp_ovr);
        check("busy", busy, exp_busy);
        check("stuck_hi", stuck_hi, exp_shi);
        check("stuck_lo", stuck_lo, exp_slo);
        if (meas_valid) meas_cnt++;
        if (overrun) ovr_cnt++;
      end
    end
  end

  task automatic drive(input bit v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    repeat (n) begin
      drive(1'b1, hi);
      if (lo > 0) drive(1'b0, lo);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_high"}, high_time, 0);
    check({tag, "_duty"}, duty_pct, 0);
    check({tag, "_valid"}, meas_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_stuck"}, {stuck_hi, stuck_lo}, 0);
    check({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    check_zero("reset");
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // 100-cycle period, 40 high: first rise only arms
    wave(40, 60, 1);
    check("arm_only_meas", meas_cnt, 0);
    wave(40, 60, 3);
    check("p100_meas_cnt", meas_cnt, 3);
    check("p100_period", period, 100);
    check("p100_high", high_time, 40);
    check("p100_duty", duty_pct, 40);

    // too-short period overruns, then 50/17
    base = ovr_cnt;
    wave(1, 2, 6);
    wave(17, 33, 4);
    check("short_ovr_cnt", ovr_cnt - base, 6);
    check("p50_period", period, 50);
    check("p50_high", high_time, 17);
    check("p50_duty", duty_pct, 34);

    // held high past the counter range
    drive(1'b1, 5000);
    check("stuck_hi_flag", stuck_hi, 1);
    check("stuck_hi_duty", duty_pct, 100);
    check("stuck_hi_period_kept", period, 50);
    drive(1'b0, 30);
    wave(40, 60, 2);
    check("unstuck_hi_flag", stuck_hi, 0);
    check("unstuck_hi_duty", duty_pct, 40);

    // held low past the counter range, then 199/200
    drive(1'b0, 5000);
    check("stuck_lo_flag", stuck_lo, 1);
    check("stuck_lo_duty", duty_pct, 0);
    wave(199, 1, 3);
    check("p200_duty", duty_pct, 99);
    check("p200_high", high_time, 199);
    check("unstuck_lo_flag", stuck_lo, 0);

    // reset in the middle of a division
    pwm_in = 1'b1;
    repeat (11) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_rst");
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b1;
    base = meas_cnt;
    drive(1'b1, 20);
    drive(1'b0, 70);
    check("post_rst_arm_only", meas_cnt - base, 0);
    wave(30, 70, 3);
    check("post_rst_duty", duty_pct, 30);

    // generator-style sweep at constant period
    for (int d = 10; d <= 90; d += 10) begin
      wave(d, 100 - d, 3);
      check("sweep_duty", duty_pct, d);
      check("sweep_period", period, 100);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
